// File: rtl/tree_reduce_seq_pkg.sv
// Shared definitions for the multi-operand tree adder blocks.
// Holds the controller state encoding, default sizes and a ceil-log2 helper.
package tree_reduce_seq_pkg;

    localparam int DEF_N = 20;
    localparam int DEF_M = 8;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Constant-foldable ceil(log2(v)); v <= 1 yields 0.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tree_reduce_seq_rca.sv
// W-bit ripple-carry adder with carry-in tied to 0.
// The MSB carry is never formed: callers size W so the sum cannot overflow.
module rca_w #(
    parameter int W = 23
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < W - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/tree_reduce_seq.sv
// Buffers a batch of M operands, reduces them pairwise in binary-tree order
// through one shared adder (one addition per cycle), then presents the sum.
module tree_reduce_seq
    import tree_reduce_seq_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M,
    parameter int W = N + clog2_f(M)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         busy
);

    // Handshakes: a word moves on a rising edge only when valid && ready are
    // both high; valid never depends on ready, ready is a pure function of state.

    localparam int LW = clog2_f(M);
    localparam int IW = (LW < 1) ? 1 : LW;

    state_t         state_q, state_d;
    logic [IW-1:0]  count_q;
    logic [IW-1:0]  level_q;
    logic [IW-1:0]  pair_q;
    logic [W-1:0]   opbuf [M];

    logic [IW-1:0]  a_idx, b_idx;
    logic [IW:0]    span;
    logic           pair_last;
    logic           last_add;
    logic [W-1:0]   add_sum;

    // Pair j at level L combines entries 2j*2^L and (2j+1)*2^L.
    assign a_idx     = IW'({pair_q, 1'b0} << level_q);
    assign b_idx     = IW'({pair_q, 1'b1} << level_q);
    assign span      = (IW+1)'(M) >> level_q;
    assign pair_last = (({1'b0, pair_q} + (IW+1)'(1)) == (span >> 1));
    assign last_add  = pair_last && (level_q == IW'(LW - 1));

    rca_w #(.W(W)) u_add (
        .a   (opbuf[a_idx]),
        .b   (opbuf[b_idx]),
        .sum (add_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (count_q == IW'(M - 1))) state_d = ST_REDUCE;
            end
            ST_REDUCE: begin
                busy = 1'b1;
                if (last_add) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            level_q <= '0;
            pair_q  <= '0;
            out_sum <= '0;
            for (int i = 0; i < M; i++) opbuf[i] <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid) begin
                        opbuf[count_q] <= {{(W-N){1'b0}}, in_data};
                        if (count_q == IW'(M - 1)) count_q <= '0;
                        else                       count_q <= count_q + IW'(1);
                    end
                end
                ST_REDUCE: begin
                    opbuf[a_idx] <= add_sum;
                    if (pair_last) begin
                        pair_q  <= '0;
                        level_q <= last_add ? '0 : level_q + IW'(1);
                    end else begin
                        pair_q <= pair_q + IW'(1);
                    end
                    if (last_add) out_sum <= add_sum;
                end
                ST_DONE: begin
                    // out_sum stays put; the buffer is wiped for the next batch.
                    if (out_ready) begin
                        level_q <= '0;
                        pair_q  <= '0;
                        for (int i = 0; i < M; i++) opbuf[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tree_reduce_seq.md
Name: tree_reduce_seq

Overview:
- Sequential multi-operand reduction controller and the initiator side of the team's ripple-carry adder datapath.
- Accepts a batch of M N-bit operands over a valid/ready stream and buffers them.
- Drives a single W-bit adder through the binary-tree reduction order, M-1 pairwise additions, one per cycle.
- Presents the final sum on a valid/ready output; sits between the operand source and the downstream result consumer.

Parameters:
- N, 20, operand width in bits.
- M, 8, operands per batch; power of 2, minimum 2.
- W, N+$clog2(M), result and buffer width; the result is guaranteed not to overflow.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; clears all state.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accept; high only in LOAD.
- in_data  in  N  operand, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_sum  out  W  reduced sum, unsigned.
- busy  out  1  high in REDUCE or DONE.

Behaviour:
- Reset values: state=LOAD, load count=0, level=0, pair index=0, all buffer entries=0, in_ready=1, out_valid=0, out_sum=0, busy=0.
- Buffer: M entries of W bits. Operands are zero-extended to W.
- LOAD:
  - An operand is accepted on a rising edge with in_valid&in_ready. It is written to buf[count], then count increments.
  - On the edge accepting operand M-1, count wraps to 0 and the state moves to REDUCE; in_ready drops the next cycle.
- REDUCE:
  - One addition per edge, at level L=0..log2(M)-1 and pair j.
  - Operation: buf[2j*2^L] <= buf[2j*2^L] + buf[(2j+1)*2^L].
  - j runs 0..M/2^(L+1)-1, then resets to 0 and L increments.
  - The adder is W bits wide with carry-in 0; its carry-out is ignored because W guarantees no overflow.
  - in_valid is ignored, and in_data is never sampled.
- Transition to DONE: on the edge performing the final addition (L=log2(M)-1, j=0), the state moves to DONE and out_sum is registered from that addition result.
- Latency: out_valid rises exactly M-1 rising edges after the edge that accepted the last operand.
- DONE:
  - out_valid=1, and out_sum is held stable until the edge where out_valid&out_ready.
  - On that edge: state=LOAD, buffer is cleared, L=0, j=0.
  - The next cycle shows in_ready=1 and out_valid=0.
  - There is no same-cycle bypass; a new batch cannot load while DONE.
- Backpressure: out_ready low in DONE holds the result indefinitely; there is no timeout.
- Input stalls: gaps in in_valid during LOAD simply pause count; partial batches persist until completed.
- Reset mid-operation: asserting rst_n low asynchronously returns to the reset values in any state. The partial batch and any pending result are discarded.
- Simultaneous events: in_valid high in REDUCE or DONE has no effect. An out_ready pulse outside DONE has no effect.
- States: LOAD, REDUCE, DONE, 2-bit encoded; the unused encoding returns to LOAD.

Decomposition:
- Shared package holds:
  - the state enum (LOAD, REDUCE, DONE);
  - a clog2 helper constant function;
  - the default N=20 and M=8 constants reused by the multi-operand tree adder blocks.
- One natural sub-module: rca_w, a parameterized W-bit ripple-carry adder with cin tied 0. It is instantiated once and fed by buffer-index muxes.

Test Plan:
- Load 1,2,3,4,5,6,7,8 with in_valid held high (M=8, N=20) -> in_ready low 1 cycle after 8th accept; out_sum=36 (0x24) with out_valid rising exactly 7 edges after last accept.
- Load eight operands of 0xFFFFF -> out_sum=0x7FFFF8 (W=23), no truncation.
- Hold out_ready low 10 cycles in DONE, toggle in_valid with data 0xAAAAA -> out_sum stable at prior value, in_ready stays 0, accepted count unchanged; release out_ready -> LOAD next cycle.
- Assert rst_n low during REDUCE at level 1 -> all outputs at reset values immediately; new batch of eight 0x00001 -> out_sum=8.
- Insert random in_valid gaps while loading 0x10,0x20,...,0x80 -> out_sum=0x240, latency still 7 edges after last accept.
- Two back-to-back batches with out_ready tied high -> results 36 then 100 (operands 9..16), with one idle LOAD handoff cycle between out handshake and the first accept.
